membus_master: RTL

Initiator for the shared 8-bit memory uniBus: accepts single-byte read/write requests from the CPU datapath over a valid/ready handshake and sequences them onto the memory responder's run/rw/address strobes and the bidirectional data bus. It drives write data, releases the bus for read data, captures it, and returns it with a one-cycle valid pulse. The block sits between the CPU control unit and the memory responder, and is the only master on the uniBus.

---
 rtl/membus_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/membus_master.sv
// membus_master: single-master sequencer for the shared 8-bit uniBus.
// Optional write read-back check: define MEMBUS_WRITE_VERIFY_EN.
module membus_master #(
  parameter int RD_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       wr_err,
  output logic       mem_run,
  output logic       mem_rw,
  output logic [7:0] mem_addr,
  inout  wire  [7:0] uniBus
);

`ifdef MEMBUS_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE,
    S_TURN, S_VISSUE, S_VWAIT, S_VCAP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_TURN
  } state_e;
`endif

  // WAIT runs RD_LAT-1 cycles; the counter counts down to zero
  localparam logic [1:0] WAIT_INIT =
    (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e     state_q, state_d;
  state_e     prev_q;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] wdata_q, wdata_d;
  logic       mem_rw_q, mem_rw_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rst_dly_q;
  logic       bus_en;
  logic       accept;
`ifdef MEMBUS_WRITE_VERIFY_EN
  logic       vmis_q, vmis_d;
`endif

  assign accept = req_valid && req_ready;

  // State, latched request and capture registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      prev_q     <= S_IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      mem_rw_q   <= 1'b1;
      mem_addr_q <= '0;
      rd_data_q  <= '0;
`ifdef MEMBUS_WRITE_VERIFY_EN
      vmis_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= state_q;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      rd_data_q  <= rd_data_d;
`ifdef MEMBUS_WRITE_VERIFY_EN
      vmis_q     <= vmis_d;
`endif
    end
  end

  // Remember reset for one cycle so the release cycle never accepts
  always_ff @(posedge CLK) begin
    rst_dly_q <= RST;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!mem_rw_q) begin
          state_d = S_TURN;
        end else if (RD_LAT > 1) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_CAPTURE;
        else cnt_d = cnt_q - 2'd1;
      end
      S_CAPTURE: state_d = S_TURN;
      S_TURN: begin
`ifdef MEMBUS_WRITE_VERIFY_EN
        if (prev_q == S_ISSUE) state_d = S_VISSUE;
        else state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef MEMBUS_WRITE_VERIFY_EN
      S_VISSUE: begin
        if (RD_LAT > 1) begin
          state_d = S_VWAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = S_VCAP;
        end
      end
      S_VWAIT: begin
        if (cnt_q == 2'd0) state_d = S_VCAP;
        else cnt_d = cnt_q - 2'd1;
      end
      S_VCAP: state_d = S_TURN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, strobe direction and read capture
  always_comb begin
    wdata_d    = wdata_q;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    rd_data_d  = rd_data_q;
    if (accept) begin
      wdata_d    = req_wdata;
      mem_rw_d   = req_rw;
      mem_addr_d = req_addr;
    end
`ifdef MEMBUS_WRITE_VERIFY_EN
    if (state_d == S_VISSUE) mem_rw_d = 1'b1;
`endif
    // idle direction is read so a stray strobe cannot write
    if (state_d == S_IDLE) mem_rw_d = 1'b1;
    if (state_q == S_CAPTURE) rd_data_d = uniBus;
  end

`ifdef MEMBUS_WRITE_VERIFY_EN
  // Compare the read-back byte against the byte just written
  always_comb begin
    vmis_d = vmis_q;
    if (state_q == S_VCAP) vmis_d = (uniBus != wdata_q);
  end
`endif

  // Outputs decoded from registered state only
  always_comb begin
    req_ready = (state_q == S_IDLE) && !RST && !rst_dly_q;
    mem_run   = !RST && ((state_q == S_ISSUE)
`ifdef MEMBUS_WRITE_VERIFY_EN
                || (state_q == S_VISSUE)
`endif
                );
    bus_en    = !RST && (state_q == S_ISSUE) && !mem_rw_q;
    rd_valid  = !RST && (state_q == S_TURN)
                && (prev_q == S_CAPTURE);
`ifdef MEMBUS_WRITE_VERIFY_EN
    wr_err    = !RST && (state_q == S_TURN)
                && (prev_q == S_VCAP) && vmis_q;
`else
    wr_err    = 1'b0;
`endif
  end

  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign rd_data  = rd_data_q;
  assign uniBus   = bus_en ? wdata_q : 8'bz;

endmodule
